// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_STALL  = 2'b01,
    HZ_FREEZE = 2'b10
  } hzState_t;

  // Index of the hard-wired zero register; writes to it are discarded,
  // so a load targeting it can never create a true dependence.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
// Holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count qualifying events, sticking at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Generates PC / pipeline-register enables and clear-to-bubble flushes for
// load-use stalls, MEM-stage redirects and data-memory wait freezes.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   HZ_RUN    | normal flow, hazard detection active
//   HZ_STALL  | bubble inserted last cycle, load-use masked this cycle
//   HZ_FREEZE | memory wait last cycle; behaves as RUN once wait drops
//   2'b11     | illegal, treated as RUN
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  mem_redirect,
  input  logic                  mem_wait,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic [1:0]            hz_state
);

  logic [1:0] stateQ;
  logic [1:0] stateD;
  logic       loadUse;
  logic       inStall;
  logic       bubble;
  logic       redirectAct;

  assign loadUse = id_ex_mem_read
                 && (id_ex_rt != REG_ADDR_W'(REG_ZERO))
                 && ((id_uses_rs && (id_ex_rt == if_id_rs))
                  || (id_uses_rt && (id_ex_rt == if_id_rt)));

  // Only the STALL encoding masks the hazard; FREEZE and the illegal
  // encoding both fall through to RUN behaviour.
  assign inStall     = (stateQ == HZ_STALL);
  assign redirectAct = !mem_wait && mem_redirect;
  assign bubble      = !mem_wait && !mem_redirect && loadUse && !inStall;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= HZ_RUN;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state selection, priority wait > redirect > load-use.
  always_comb begin
    stateD = HZ_RUN;
    if (mem_wait) begin
      stateD = HZ_FREEZE;
    end else if (mem_redirect) begin
      stateD = HZ_RUN;
    end else if (bubble) begin
      stateD = HZ_STALL;
    end
  end

  // Enable and flush decode; everything is held off while reset is high.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (reset || mem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (bubble) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign hz_state = stateQ;

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirectAct),
    .count (flush_cnt)
  );
`else
  // Counter width only matters when the counters are built.
  if (CNT_W < 1) begin : gNoCounters
  end
  logic unusedRedirect;
  assign unusedRedirect = redirectAct;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [RW-1:0] ifIdRs, ifIdRt, idExRt;
  logic          idUsesRs, idUsesRt, idExMemRead, memRedirect, memWait;
  logic          pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic          ifIdFlush, idExFlush, exMemFlush;
  logic [1:0]    hzState;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stallCnt, flushCnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] obsEn;
  logic [2:0] obsFl;
  assign obsEn = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn};
  assign obsFl = {ifIdFlush, idExFlush, exMemFlush};

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_id_rs       (ifIdRs),
    .if_id_rt       (ifIdRt),
    .id_uses_rs     (idUsesRs),
    .id_uses_rt     (idUsesRt),
    .id_ex_mem_read (idExMemRead),
    .id_ex_rt       (idExRt),
    .mem_redirect   (memRedirect),
    .mem_wait       (memWait),
    .pc_en          (pcEn),
    .if_id_en       (ifIdEn),
    .id_ex_en       (idExEn),
    .ex_mem_en      (exMemEn),
    .mem_wb_en      (memWbEn),
    .if_id_flush    (ifIdFlush),
    .id_ex_flush    (idExFlush),
    .ex_mem_flush   (exMemFlush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt      (stallCnt),
    .flush_cnt      (flushCnt),
`endif
    .hz_state       (hzState)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [4:0] en;
    logic [2:0] fl;
    logic       bub;
  } exp_t;

  // Reference: expected outputs from the rules, given whether the previous
  // cycle inserted a bubble.
  function automatic exp_t refCycle(input bit prevBubble);
    exp_t e;
    bit hit;
    hit = idExMemRead && (idExRt != 0) &&
          ((idUsesRs && idExRt == ifIdRs) || (idUsesRt && idExRt == ifIdRt));
    e.bub = 1'b0;
    if (memWait) begin
      e.en = 5'b00000; e.fl = 3'b000;
    end else if (memRedirect) begin
      e.en = 5'b11111; e.fl = 3'b111;
    end else if (hit && !prevBubble) begin
      e.en = 5'b00111; e.fl = 3'b010; e.bub = 1'b1;
    end else begin
      e.en = 5'b11111; e.fl = 3'b000;
    end
    return e;
  endfunction

  task automatic setIn(input logic mr, input logic [RW-1:0] lrt,
                       input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic ur, input logic ut,
                       input logic red, input logic wt);
    idExMemRead = mr; idExRt = lrt; ifIdRs = rs; ifIdRt = rt;
    idUsesRs = ur; idUsesRt = ut; memRedirect = red; memWait = wt;
  endtask

  task automatic clearIn;
    setIn(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clearIn();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    reset = 1'b1;
    setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obsEn !== 5'b00000 || obsFl !== 3'b000 || hzState !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: en=%b fl=%b st=%0d, need en=00000 fl=000 st=0", obsEn, obsFl, hzState);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stallCnt !== 4'd0 || flushCnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: stall=%0d flush=%0d, need 0 0", stallCnt, flushCnt);
    end
`endif
    clearIn();
    reset = 1'b0;
    #1;
    checks++;
    if (obsEn !== 5'b11111 || obsFl !== 3'b000 || hzState !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: en=%b fl=%b st=%0d, need en=11111 fl=000 st=0", obsEn, obsFl, hzState);
    end
  endtask

  task automatic test_load_use;
    tick();
    setIn(1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obsEn !== 5'b00111 || obsFl !== 3'b010 || hzState !== 2'b00) begin
      errors++;
      $display("FAIL lu_bubble: en=%b fl=%b st=%0d, need en=00111 fl=010 st=0", obsEn, obsFl, hzState);
    end
    tick();
    @(negedge clk);
    checks++;
    if (obsEn !== 5'b11111 || obsFl !== 3'b000 || hzState !== 2'b01) begin
      errors++;
      $display("FAIL lu_stall: en=%b fl=%b st=%0d, need en=11111 fl=000 st=1", obsEn, obsFl, hzState);
    end
    tick();
    clearIn();
    @(negedge clk);
    checks++;
    if (hzState !== 2'b00) begin
      errors++;
      $display("FAIL lu_back_to_run: st=%0d, need 0", hzState);
    end
    // rt-side dependence also stalls
    setIn(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (obsEn !== 5'b00111 || obsFl !== 3'b010) begin
      errors++;
      $display("FAIL lu_rt: en=%b fl=%b, need en=00111 fl=010", obsEn, obsFl);
    end
    tick();
    clearIn();
    tick();
  endtask

  task automatic test_load_zero;
    tick();
    setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obsEn !== 5'b11111 || obsFl !== 3'b000) begin
      errors++;
      $display("FAIL lu_zero: en=%b fl=%b, need en=11111 fl=000", obsEn, obsFl);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hzState !== 2'b00) begin
      errors++;
      $display("FAIL lu_zero_state: st=%0d, need 0", hzState);
    end
    clearIn();
  endtask

  task automatic test_redirect_lu;
    tick();
    setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obsEn !== 5'b11111 || obsFl !== 3'b111) begin
      errors++;
      $display("FAIL redirect_lu: en=%b fl=%b, need en=11111 fl=111", obsEn, obsFl);
    end
    tick();
    clearIn();
    @(negedge clk);
    checks++;
    if (hzState !== 2'b00) begin
      errors++;
      $display("FAIL redirect_lu_state: st=%0d, need 0", hzState);
    end
  endtask

  task automatic test_wait_redirect;
    tick();
    setIn(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obsEn !== 5'b00000 || obsFl !== 3'b000) begin
        errors++;
        $display("FAIL wait_freeze[%0d]: en=%b fl=%b, need en=00000 fl=000", c, obsEn, obsFl);
      end
      tick();
      checks++;
      if (hzState !== 2'b10) begin
        errors++;
        $display("FAIL wait_state[%0d]: st=%0d, need 2", c, hzState);
      end
    end
    memWait = 1'b0;
    @(negedge clk);
    checks++;
    if (obsEn !== 5'b11111 || obsFl !== 3'b111) begin
      errors++;
      $display("FAIL wait_release: en=%b fl=%b, need en=11111 fl=111", obsEn, obsFl);
    end
    tick();
    clearIn();
    checks++;
    if (hzState !== 2'b00) begin
      errors++;
      $display("FAIL wait_release_state: st=%0d, need 0", hzState);
    end
  endtask

  task automatic test_reset_mid_stall;
    tick();
    setIn(1'b1, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    clearIn();
    checks++;
    if (hzState !== 2'b01) begin
      errors++;
      $display("FAIL mid_stall_setup: st=%0d, need 1", hzState);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (hzState !== 2'b00 || obsEn !== 5'b00000 || obsFl !== 3'b000) begin
      errors++;
      $display("FAIL mid_stall_reset: st=%0d en=%b fl=%b, need st=0 en=00000 fl=000", hzState, obsEn, obsFl);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (hzState !== 2'b00 || obsEn !== 5'b11111 || obsFl !== 3'b000) begin
      errors++;
      $display("FAIL mid_stall_release: st=%0d en=%b fl=%b, need st=0 en=11111 fl=000", hzState, obsEn, obsFl);
    end
  endtask

  task automatic test_random;
    bit   prevWait, prevBub;
    int   expSt, mStall, mFlush;
    exp_t e;
    doReset();
    prevWait = 0; prevBub = 0; mStall = 0; mFlush = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      idExMemRead = ($urandom_range(0, 1) == 1);
      idExRt      = RW'($urandom_range(0, 3));
      ifIdRs      = RW'($urandom_range(0, 3));
      ifIdRt      = RW'($urandom_range(0, 3));
      idUsesRs    = ($urandom_range(0, 3) != 0);
      idUsesRt    = ($urandom_range(0, 1) == 1);
      memRedirect = ($urandom_range(0, 6) == 0);
      memWait     = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e     = refCycle(prevBub);
      expSt = prevWait ? 2 : (prevBub ? 1 : 0);
      checks++;
      if (obsEn !== e.en || obsFl !== e.fl) begin
        errors++;
        $display("FAIL rand_out[%0d]: en=%b fl=%b, need en=%b fl=%b", i, obsEn, obsFl, e.en, e.fl);
      end
      checks++;
      if (hzState !== 2'(expSt)) begin
        errors++;
        $display("FAIL rand_state[%0d]: st=%0d, need %0d", i, hzState, expSt);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stallCnt !== CW'(mStall) || flushCnt !== CW'(mFlush)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: stall=%0d flush=%0d, need %0d %0d", i, stallCnt, flushCnt, mStall, mFlush);
      end
      if (e.bub && mStall < 15) mStall++;
      if (!memWait && memRedirect && mFlush < 15) mFlush++;
`endif
      prevWait = memWait;
      prevBub  = e.bub;
    end
    tick();
    clearIn();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_counter_sat;
    doReset();
    for (int n = 0; n < 20; n++) begin
      tick();
      setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      clearIn();
    end
    tick();
    checks++;
    if (stallCnt !== 4'd15 || flushCnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_sat: stall=%0d flush=%0d, need 15 0", stallCnt, flushCnt);
    end
    for (int n = 0; n < 17; n++) begin
      setIn(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, (n % 4) == 3);
      tick();
    end
    clearIn();
    tick();
    checks++;
    if (flushCnt !== 4'd13) begin
      errors++;
      $display("FAIL flush_cnt: flush=%0d, need 13", flushCnt);
    end
    for (int n = 0; n < 4; n++) begin
      setIn(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    clearIn();
    tick();
    checks++;
    if (flushCnt !== 4'd15) begin
      errors++;
      $display("FAIL flush_sat: flush=%0d, need 15", flushCnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    clearIn();
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_load_zero();
    test_redirect_lu();
    test_wait_redirect();
    test_reset_mid_stall();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_counter_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It detects load-use hazards and inserts one bubble. It flushes the three younger stages when a branch, jump or jr redirect resolves in MEM. It freezes the whole pipeline while data memory signals a wait. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and complements the existing forwarding unit.

## Interface
- REG_ADDR_W, 5: register-file address width
- CNT_W, 32: performance counter width (used only with HAZARD_PERF_CNT_EN)

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- if_id_rs  in  REG_ADDR_W  rs field of the IF/ID instruction
- if_id_rt  in  REG_ADDR_W  rt field of the IF/ID instruction
- id_uses_rs  in  1  IF/ID instruction reads rs
- id_uses_rt  in  1  IF/ID instruction reads rt (R-type, beq, bne, sw)
- id_ex_mem_read  in  1  ID/EX holds a load
- id_ex_rt  in  REG_ADDR_W  destination of the load in ID/EX
- mem_redirect  in  1  taken beq/bne, j, jal or jr in EX/MEM
- mem_wait  in  1  data memory not ready
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  synchronous clear-to-bubble for the next edge
- hz_state  out  2  current FSM state
- stall_cnt, flush_cnt  out  CNT_W each  present only with HAZARD_PERF_CNT_EN

## Operation
- Load-use condition: `lu` = id_ex_mem_read & (id_ex_rt != 0) & ((id_uses_rs & id_ex_rt == if_id_rs) | (id_uses_rt & id_ex_rt == if_id_rt)).
- FSM states: RUN=2'b00, STALL=2'b01, FREEZE=2'b10. 2'b11 is illegal and decodes as RUN.
- Priority each cycle: mem_wait > mem_redirect > lu.
- **mem_wait=1**
  - All enables 0, all flushes 0.
  - Next state FREEZE.
  - A redirect or lu present in this cycle is not acted on. It is re-evaluated after the freeze, because the frozen inputs persist.
- **mem_redirect=1**, no wait
  - All enables 1.
  - if_id_flush = id_ex_flush = ex_mem_flush = 1.
  - Next state RUN, including from STALL.
- **lu=1 in RUN**, no wait, no redirect
  - pc_en = if_id_en = 0; id_ex_flush = 1; other enables 1.
  - Next state STALL.
- **STALL**
  - lu is masked.
  - All enables 1, no flushes.
  - Next state RUN.
- **FREEZE, mem_wait=0**: act as RUN (hazard evaluation applies in the same cycle).
- **Otherwise**: all enables 1, no flushes, stay in or return to RUN.
- Register $0 never causes a stall.

## Timing
- Enables and flushes are combinational from the inputs and the registered state. They are valid before the same rising edge, with zero added latency.
- A load-use hazard costs exactly 1 bubble cycle.
- A redirect costs 3 flushed slots.
- Reset behaviour:
  - While reset is high: hz_state = RUN, all enables 0, all flushes 0, counters 0.
  - After release, the first cycle behaves as RUN.
  - Reset asserted mid-STALL or mid-FREEZE returns to RUN asynchronously. No pending hazard is remembered.
- Simultaneous redirect and lu: redirect wins. No bubble is inserted, because the dependent instruction is flushed.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle that lu causes a bubble.
  - flush_cnt increments on every redirect cycle.
  - Neither counter counts during mem_wait.
  - Both saturate at 2^CNT_W−1.
  - Both clear on reset.
- HAZARD_PERF_CNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package hazard_pkg holds the state encodings HZ_RUN, HZ_STALL and HZ_FREEZE, and the REG_ZERO constant.
- Sub-module hazard_sat_counter (parameter CNT_W; ports clk, reset, inc, count) is instantiated twice under HAZARD_PERF_CNT_EN.

## Test plan
- **Load-use**
  - Stimulus: lw $t0 in ID/EX (id_ex_mem_read=1, id_ex_rt=8), add with if_id_rs=8, id_uses_rs=1.
  - Required: that cycle pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle hz_state=STALL with all enables 1. Then RUN.
- **Load to $0**
  - Stimulus: id_ex_rt=0 with a matching if_id_rs=0.
  - Required: no stall; hz_state stays RUN.
- **Redirect with simultaneous lu**
  - Stimulus: mem_redirect=1 and lu=1 in the same cycle.
  - Required: three flushes = 1, pc_en=1, no stall, next state RUN.
- **Wait during a pending redirect**
  - Stimulus: mem_wait=1 for 3 cycles with mem_redirect held high.
  - Required: all enables 0 for those 3 cycles, hz_state=FREEZE. Flushes fire on the first cycle after mem_wait drops.
- **Reset mid-STALL**
  - Stimulus: reset pulse while hz_state=STALL.
  - Required: hz_state=RUN and enables 0 immediately. Normal RUN outputs after release.
- **Counter saturation** (HAZARD_PERF_CNT_EN, CNT_W=4)
  - Stimulus: 20 load-use stalls.
  - Required: stall_cnt=15.
